// File: rtl/sb_mac16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sb_mac16 : 16-bit DSP slice, two add/sub/accumulate lanes with mult feeds  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sb_mac16 #(
   parameter bit       A_REG                 = 1'b0,
   parameter bit       B_REG                 = 1'b0,
   parameter bit       C_REG                 = 1'b0,
   parameter bit       D_REG                 = 1'b0,
   parameter bit       A_SIGNED              = 1'b0,
   parameter bit       B_SIGNED              = 1'b0,
   parameter bit       TOPADDSUB_UPPERINPUT  = 1'b0,
   parameter bit       BOTADDSUB_UPPERINPUT  = 1'b0,
   parameter bit [1:0] TOPADDSUB_LOWERINPUT  = 2'b00,
   parameter bit [1:0] BOTADDSUB_LOWERINPUT  = 2'b00,
   parameter bit [1:0] TOPADDSUB_CARRYSELECT = 2'b00,
   parameter bit [1:0] BOTADDSUB_CARRYSELECT = 2'b00,
   parameter bit [1:0] TOPOUTPUT_SELECT      = 2'b00,
   parameter bit [1:0] BOTOUTPUT_SELECT      = 2'b00
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ce,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic [15:0] i_c,
   input  logic [15:0] i_d,
   input  logic        i_ahold,
   input  logic        i_bhold,
   input  logic        i_chold,
   input  logic        i_dhold,
   input  logic        i_oholdtop,
   input  logic        i_oholdbot,
   input  logic        i_oloadtop,
   input  logic        i_oloadbot,
   input  logic        i_addsubtop,
   input  logic        i_addsubbot,
   input  logic        i_ci,
   output logic [31:0] o_o,
   output logic        o_co
);

   logic [15:0] r_a, r_b, r_c, r_d;
   logic [15:0] r_acc_top, r_acc_bot;
   logic [15:0] w_a, w_b, w_c, w_d;
   logic        w_a_sx, w_b_sx;
   logic [15:0] w_at_ext, w_bt_ext, w_ab_ext, w_bb_ext;
   logic [31:0] w_a_ext, w_b_ext;
   logic [15:0] w_p8_top, w_p8_bot;
   logic [31:0] w_p16;
   logic [15:0] w_top_up, w_bot_up, w_top_lo, w_bot_lo;
   logic        w_top_cin, w_bot_cin;
   logic [16:0] w_top_sum, w_bot_sum;
   logic [15:0] w_top_out, w_bot_out;

   // Input registers are always present; the X_REG parameters only pick the tap.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= '0;
         r_d <= '0;
      end else if (i_ce) begin
         if (!i_ahold) r_a <= i_a;
         if (!i_bhold) r_b <= i_b;
         if (!i_chold) r_c <= i_c;
         if (!i_dhold) r_d <= i_d;
      end
   end

   assign w_a = A_REG ? r_a : i_a;
   assign w_b = B_REG ? r_b : i_b;
   assign w_c = C_REG ? r_c : i_c;
   assign w_d = D_REG ? r_d : i_d;

   // Operands are sign/zero-extended to the result width, so a plain
   // unsigned multiply yields the correct signed or mixed low-order bits.
   assign w_a_sx   = A_SIGNED & w_a[15];
   assign w_b_sx   = B_SIGNED & w_b[15];
   assign w_at_ext = {{8{A_SIGNED & w_a[15]}}, w_a[15:8]};
   assign w_bt_ext = {{8{B_SIGNED & w_b[15]}}, w_b[15:8]};
   assign w_ab_ext = {{8{A_SIGNED & w_a[7]}},  w_a[7:0]};
   assign w_bb_ext = {{8{B_SIGNED & w_b[7]}},  w_b[7:0]};
   assign w_a_ext  = {{16{w_a_sx}}, w_a};
   assign w_b_ext  = {{16{w_b_sx}}, w_b};

   assign w_p8_top = w_at_ext * w_bt_ext;
   assign w_p8_bot = w_ab_ext * w_bb_ext;
   assign w_p16    = w_a_ext * w_b_ext;

   assign w_top_up = TOPADDSUB_UPPERINPUT ? w_c : r_acc_top;
   assign w_bot_up = BOTADDSUB_UPPERINPUT ? w_d : r_acc_bot;

   always_comb begin
      w_top_lo = '0;
      case (TOPADDSUB_LOWERINPUT)
         2'b00:   w_top_lo = w_a;
         2'b01:   w_top_lo = w_p8_top;
         2'b10:   w_top_lo = w_p16[31:16];
         default: w_top_lo = '0;
      endcase
   end

   always_comb begin
      w_bot_lo = '0;
      case (BOTADDSUB_LOWERINPUT)
         2'b00:   w_bot_lo = w_b;
         2'b01:   w_bot_lo = w_p8_bot;
         2'b10:   w_bot_lo = w_p16[15:0];
         default: w_bot_lo = '0;
      endcase
   end

   // In subtract mode bit 16 of the 17-bit difference is the borrow flag.
   assign w_bot_cin = BOTADDSUB_CARRYSELECT[1] ? i_ci : BOTADDSUB_CARRYSELECT[0];
   assign w_bot_sum = i_addsubbot
                    ? ({1'b0, w_bot_up} - {1'b0, w_bot_lo} - {16'd0, w_bot_cin})
                    : ({1'b0, w_bot_up} + {1'b0, w_bot_lo} + {16'd0, w_bot_cin});

   assign w_top_cin = TOPADDSUB_CARRYSELECT[1] ? w_bot_sum[16] : TOPADDSUB_CARRYSELECT[0];
   assign w_top_sum = i_addsubtop
                    ? ({1'b0, w_top_up} - {1'b0, w_top_lo} - {16'd0, w_top_cin})
                    : ({1'b0, w_top_up} + {1'b0, w_top_lo} + {16'd0, w_top_cin});

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc_top <= '0;
         r_acc_bot <= '0;
      end else if (i_ce) begin
         if (!i_oholdtop) r_acc_top <= i_oloadtop ? w_c : w_top_sum[15:0];
         if (!i_oholdbot) r_acc_bot <= i_oloadbot ? w_d : w_bot_sum[15:0];
      end
   end

   always_comb begin
      w_top_out = '0;
      case (TOPOUTPUT_SELECT)
         2'b00:   w_top_out = w_top_sum[15:0];
         2'b01:   w_top_out = r_acc_top;
         2'b10:   w_top_out = w_p8_top;
         default: w_top_out = w_p16[31:16];
      endcase
   end

   always_comb begin
      w_bot_out = '0;
      case (BOTOUTPUT_SELECT)
         2'b00:   w_bot_out = w_bot_sum[15:0];
         2'b01:   w_bot_out = r_acc_bot;
         2'b10:   w_bot_out = w_p8_bot;
         default: w_bot_out = w_p16[15:0];
      endcase
   end

   assign o_o  = {w_top_out, w_bot_out};
   assign o_co = w_top_sum[16];

endmodule
`default_nettype wire

// File: tb/tb_sb_mac16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sb_mac16 : directed self-checking bench over several sb_mac16 configs   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sb_mac16;

   logic        clk = 1'b0;
   logic        rst_n, ce, ci;
   logic [15:0] a, b, c, d;
   logic        ahold, bhold, chold, dhold;
   logic        oholdtop, oholdbot, oloadtop, oloadbot;
   logic        addsubtop, addsubbot;

   logic [31:0] o_ofs, o_chn, o_ps, o_pu, o_p8, o_acc, o_reg;
   logic        co_ofs, co_chn, co_ps, co_pu, co_p8, co_acc, co_reg;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Address-offset configuration: O = {C-A, D-B}
   sb_mac16 #(.TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1)) u_ofs (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_ofs), .o_co(co_ofs));

   // Full carry chain CI -> bottom -> top
   sb_mac16 #(.TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
              .TOPADDSUB_CARRYSELECT(2'b10), .BOTADDSUB_CARRYSELECT(2'b10)) u_chn (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_chn), .o_co(co_chn));

   sb_mac16 #(.A_SIGNED(1'b1), .B_SIGNED(1'b1),
              .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)) u_ps (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_ps), .o_co(co_ps));

   sb_mac16 #(.TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)) u_pu (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_pu), .o_co(co_pu));

   sb_mac16 #(.A_SIGNED(1'b1), .B_SIGNED(1'b1),
              .TOPOUTPUT_SELECT(2'b10), .BOTOUTPUT_SELECT(2'b10)) u_p8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_p8), .o_co(co_p8));

   sb_mac16 #(.BOTOUTPUT_SELECT(2'b01)) u_acc (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_acc), .o_co(co_acc));

   sb_mac16 #(.A_REG(1'b1), .B_REG(1'b1),
              .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11)) u_reg (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .i_ahold(ahold), .i_bhold(bhold), .i_chold(chold), .i_dhold(dhold),
      .i_oholdtop(oholdtop), .i_oholdbot(oholdbot), .i_oloadtop(oloadtop), .i_oloadbot(oloadbot),
      .i_addsubtop(addsubtop), .i_addsubbot(addsubbot), .i_ci(ci), .o_o(o_reg), .o_co(co_reg));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; ci = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      ahold = 1'b0; bhold = 1'b0; chold = 1'b0; dhold = 1'b0;
      oholdtop = 1'b0; oholdbot = 1'b0; oloadtop = 1'b0; oloadbot = 1'b0;
      addsubtop = 1'b0; addsubbot = 1'b0;

      // Reset with CE low still clears the registers
      tick();
      tick();
      check("rst_acc", {16'd0, o_acc[15:0]}, 32'h0000_0000);
      check("rst_reg", o_reg, 32'h0000_0000);
      rst_n = 1'b1;

      // Address-offset subtract, combinational with CE low
      addsubtop = 1'b1; addsubbot = 1'b1;
      a = 16'h0000; b = 16'h1000; c = 16'h0000; d = 16'h0123;
      #1;
      check("ofs_o", o_ofs, 32'h0000_F123);
      check("ofs_co", {31'd0, co_ofs}, 32'd0);
      c = 16'h0005; a = 16'h0006;
      #1;
      check("ofs_borrow_o", o_ofs, 32'hFFFF_F123);
      check("ofs_borrow_co", {31'd0, co_ofs}, 32'd1);
      c = 16'h0007; a = 16'h0007;
      #1;
      check("ofs_equal_co", {31'd0, co_ofs}, 32'd0);

      // Chained add and subtract through the carry chain
      addsubtop = 1'b0; addsubbot = 1'b0; ci = 1'b0;
      d = 16'h0001; b = 16'hFFFF; c = 16'h0002; a = 16'h0003;
      #1;
      check("chn_add_o", o_chn, 32'h0006_0000);
      check("chn_add_co", {31'd0, co_chn}, 32'd0);
      ci = 1'b1; d = 16'hFFFF; b = 16'h0000; c = 16'hFFFF; a = 16'h0000;
      #1;
      check("chn_ci_o", o_chn, 32'h0000_0000);
      check("chn_ci_co", {31'd0, co_chn}, 32'd1);
      addsubtop = 1'b1; addsubbot = 1'b1; ci = 1'b0;
      d = 16'h0000; b = 16'h0001; c = 16'h0005; a = 16'h0002;
      #1;
      check("chn_sub_o", o_chn, 32'h0002_FFFF);
      check("chn_sub_co", {31'd0, co_chn}, 32'd0);

      // Multipliers
      a = 16'hFFFE; b = 16'h0003;
      #1;
      check("p16_signed", o_ps, 32'hFFFF_FFFA);
      check("p16_unsigned", o_pu, 32'h0002_FFFA);
      a = 16'hFF02; b = 16'h0303;
      #1;
      check("p8_signed", o_p8, 32'hFFFD_0006);

      // Bottom-lane accumulate of B
      addsubtop = 1'b0; addsubbot = 1'b0;
      ce = 1'b1; rst_n = 1'b0; b = 16'h0005; d = 16'h0000;
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("acc_3", {16'd0, o_acc[15:0]}, 32'h0000_000F);
      oholdbot = 1'b1;
      tick();
      check("acc_hold", {16'd0, o_acc[15:0]}, 32'h0000_000F);
      oholdbot = 1'b0; oloadbot = 1'b1; d = 16'h1234;
      tick();
      check("acc_load", {16'd0, o_acc[15:0]}, 32'h0000_1234);
      oholdbot = 1'b1; d = 16'h5555;
      tick();
      check("acc_hold_wins", {16'd0, o_acc[15:0]}, 32'h0000_1234);
      oholdbot = 1'b0; oloadbot = 1'b0;
      tick();
      check("acc_after_load", {16'd0, o_acc[15:0]}, 32'h0000_1239);

      // Reset with CE low, then resume
      ce = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("acc_mid_rst", {16'd0, o_acc[15:0]}, 32'h0000_0000);
      ce = 1'b1;
      tick();
      check("acc_resume", {16'd0, o_acc[15:0]}, 32'h0000_0005);
      ce = 1'b0;
      tick();
      check("acc_ce_freeze", {16'd0, o_acc[15:0]}, 32'h0000_0005);

      // Wrap-around mod 2^16
      ce = 1'b1; oloadbot = 1'b1; d = 16'hFFFE;
      tick();
      oloadbot = 1'b0;
      tick();
      check("acc_wrap", {16'd0, o_acc[15:0]}, 32'h0000_0003);

      // Registered operands
      a = 16'h0002; b = 16'h0003;
      tick();
      check("reg_capture", o_reg, 32'h0000_0006);
      ahold = 1'b1; a = 16'h0004;
      tick();
      check("reg_ahold", o_reg, 32'h0000_0006);
      ahold = 1'b0;
      #1;
      check("reg_latency", o_reg, 32'h0000_0006);
      tick();
      check("reg_update", o_reg, 32'h0000_000C);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
